// File: rtl/shared_reg_pkg.sv
// +--------------------------------------------------------------------------+
// | shared_reg_pkg: shared constants and types for the shared-register arbiter |
// | Revision: 1.0                                                              |
// +--------------------------------------------------------------------------+
`default_nettype none

package shared_reg_pkg;

  localparam int WIDTH_DEF    = 4;
  localparam int NREQ_DEF     = 4;
  localparam int MAX_HOLD_DEF = 8;

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } state_e;

  // Index width for an n-entry requester set; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/shared_reg_arbiter_rr_pick.sv
// +--------------------------------------------------------------------------+
// | rr_pick: combinational round-robin picker, first set req from ptr upward  |
// | Revision: 1.0                                                              |
// +--------------------------------------------------------------------------+
`default_nettype none

module rr_pick
  import shared_reg_pkg::*;
#(
  parameter int NREQ  = NREQ_DEF,
  parameter int IDX_W = idx_w(NREQ)
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] winner,
  output logic             any_req
);

  int idx;

  // Scan from the farthest offset down so the closest set bit to ptr wins last.
  always_comb begin
    winner  = '0;
    any_req = |req;
    idx     = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (req[IDX_W'(idx)]) winner = IDX_W'(idx);
    end
  end

endmodule

`default_nettype wire

// File: rtl/shared_reg_arbiter.sv
// +--------------------------------------------------------------------------+
// | shared_reg_arbiter: round-robin owner of one shared holding register Q    |
// | Revision: 1.0                                                              |
// +--------------------------------------------------------------------------+
`default_nettype none

module shared_reg_arbiter
  import shared_reg_pkg::*;
#(
  parameter int WIDTH    = WIDTH_DEF,
  parameter int NREQ     = NREQ_DEF,
  parameter int MAX_HOLD = MAX_HOLD_DEF
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NREQ-1:0]           req,
  input  logic [NREQ*WIDTH-1:0]     wdata,
  output logic [NREQ-1:0]           gnt,
  output logic [idx_w(NREQ)-1:0]    owner,
  output logic                      preempt,
  output logic [WIDTH-1:0]          Q
);

  localparam int IDX_W  = idx_w(NREQ);
  localparam int HCNT_W = $clog2(MAX_HOLD + 1);

  state_e              state_q, state_d;
  logic [NREQ-1:0]     gnt_q, gnt_d;
  logic [IDX_W-1:0]    owner_q, owner_d;
  logic                preempt_q, preempt_d;
  logic [WIDTH-1:0]    q_q, q_d;
  logic [IDX_W-1:0]    ptr_q, ptr_d;
  logic [HCNT_W-1:0]   hcnt_q, hcnt_d;

  logic [IDX_W-1:0]    winner;
  logic                any_req;
  logic [IDX_W-1:0]    next_ptr;
  logic [WIDTH-1:0]    wdata_arr [NREQ];

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_unpack
      assign wdata_arr[gi] = wdata[gi*WIDTH +: WIDTH];
    end
  endgenerate

  rr_pick #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .req     (req),
    .ptr     (ptr_q),
    .winner  (winner),
    .any_req (any_req)
  );

  // Explicit wrap keeps non-power-of-two requester counts in range.
  assign next_ptr = (owner_q == IDX_W'(NREQ - 1)) ? '0 : owner_q + 1'b1;

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    owner_d   = owner_q;
    preempt_d = 1'b0;
    q_d       = q_q;
    ptr_d     = ptr_q;
    hcnt_d    = hcnt_q;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d        = OWN;
          gnt_d          = '0;
          gnt_d[winner]  = 1'b1;
          owner_d        = winner;
          hcnt_d         = HCNT_W'(1);
        end
      end
      OWN: begin
        if (req[owner_q]) begin
          q_d = wdata_arr[owner_q];
          if (hcnt_q == HCNT_W'(MAX_HOLD)) begin
            gnt_d     = '0;
            preempt_d = 1'b1;
            ptr_d     = next_ptr;
            hcnt_d    = '0;
            state_d   = IDLE;
          end else begin
            hcnt_d = hcnt_q + 1'b1;
          end
        end else begin
          gnt_d   = '0;
          ptr_d   = next_ptr;
          hcnt_d  = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      owner_q   <= '0;
      preempt_q <= 1'b0;
      q_q       <= '0;
      ptr_q     <= '0;
      hcnt_q    <= '0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      owner_q   <= owner_d;
      preempt_q <= preempt_d;
      q_q       <= q_d;
      ptr_q     <= ptr_d;
      hcnt_q    <= hcnt_d;
    end
  end

  assign gnt     = gnt_q;
  assign owner   = owner_q;
  assign preempt = preempt_q;
  assign Q       = q_q;

endmodule

`default_nettype wire

// File: tb/tb_shared_reg_arbiter.sv
// +--------------------------------------------------------------------------+
// | tb_shared_reg_arbiter: scoreboard bench with a cycle-level reference model |
// | Revision: 1.0                                                              |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_shared_reg_arbiter;

  localparam int N    = 4;
  localparam int W    = 4;
  localparam int MAXH = 8;

  typedef struct {
    logic [N-1:0] gnt;
    logic [1:0]   owner;
    logic         preempt;
    logic [W-1:0] q;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [N-1:0]  req = '0;
  logic [N*W-1:0] wdata = '0;
  logic [N-1:0]  gnt;
  logic [1:0]    owner;
  logic          preempt;
  logic [W-1:0]  q;

  logic [2:0]    req3 = '0;
  logic [11:0]   wdata3 = '0;
  logic [2:0]    gnt3;
  logic [1:0]    owner3;
  logic          preempt3;
  logic [3:0]    q3;

  int errors = 0;
  int checks = 0;

  exp_t sb[$];

  bit           m_busy = 0;
  int           m_cur = 0, m_held = 0, m_ptr = 0, m_owner = 0;
  logic [W-1:0] m_q = '0;

  always #5 clk = ~clk;

  shared_reg_arbiter #(.WIDTH(W), .NREQ(N), .MAX_HOLD(MAXH)) u_dut (
    .clk(clk), .reset_n(reset_n), .req(req), .wdata(wdata),
    .gnt(gnt), .owner(owner), .preempt(preempt), .Q(q)
  );

  shared_reg_arbiter #(.WIDTH(4), .NREQ(3), .MAX_HOLD(2)) u_dut3 (
    .clk(clk), .reset_n(reset_n), .req(req3), .wdata(wdata3),
    .gnt(gnt3), .owner(owner3), .preempt(preempt3), .Q(q3)
  );

  task automatic chk(input string name, input int act, input int req_v);
    checks++;
    if (act != req_v) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req_v, $time);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_cur = 0; m_held = 0; m_ptr = 0; m_owner = 0; m_q = '0;
    sb.delete();
  endtask

  // One clock edge of the arbitration rules, applied to the inputs held across it.
  task automatic model_step(input logic [N-1:0] r, input logic [N*W-1:0] d);
    exp_t e;
    bit   pre;
    int   i;
    pre = 0;
    if (!m_busy) begin
      for (int off = 0; off < N; off++) begin
        i = (m_ptr + off) % N;
        if (r[i] && !m_busy) begin
          m_busy = 1; m_cur = i; m_held = 1; m_owner = i;
        end
      end
    end else if (r[m_cur]) begin
      m_q = d[m_cur*W +: W];
      if (m_held == MAXH) begin
        m_busy = 0; pre = 1; m_ptr = (m_cur + 1) % N;
      end else begin
        m_held++;
      end
    end else begin
      m_busy = 0; m_ptr = (m_cur + 1) % N;
    end
    e.gnt     = m_busy ? N'(1 << m_cur) : '0;
    e.owner   = 2'(m_owner);
    e.preempt = pre;
    e.q       = m_q;
    sb.push_back(e);
  endtask

  task automatic drive(input logic [N-1:0] r, input logic [N*W-1:0] d);
    @(negedge clk);
    #1;
    req   = r;
    wdata = d;
    model_step(r, d);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (reset_n && sb.size() > 0) begin
      e = sb.pop_front();
      chk("gnt", int'(gnt), int'(e.gnt));
      chk("owner", int'(owner), int'(e.owner));
      chk("preempt", int'(preempt), int'(e.preempt));
      chk("Q", int'(q), int'(e.q));
    end
  end

  always @(negedge clk) begin
    if (reset_n) chk("owner3_range", int'(owner3 < 2'd3), 1);
  end

  // Three-requester instance: wrap from ptr=2 to requester 0, then release moves ptr to 1.
  initial begin
    @(posedge reset_n);
    @(negedge clk); #2; req3 = 3'b010; wdata3 = 12'h321;
    @(negedge clk); #2;
    @(negedge clk); #2; req3 = 3'b000;
    @(negedge clk); #2; req3 = 3'b011;
    @(negedge clk); #2;
    chk("n3_wrap_gnt", int'(gnt3), 1);
    chk("n3_wrap_owner", int'(owner3), 0);
    req3 = 3'b000;
    @(negedge clk); #2;
    chk("n3_release_gnt", int'(gnt3), 0);
    req3 = 3'b101;
    @(negedge clk); #2;
    chk("n3_ptr1_owner", int'(owner3), 2);
    chk("n3_ptr1_gnt", int'(gnt3), 4);
    req3 = 3'b000;
  end

  initial begin
    logic [N-1:0]   r;
    logic [N*W-1:0] d;
    int             c;

    #12;
    chk("rst_gnt", int'(gnt), 0);
    chk("rst_owner", int'(owner), 0);
    chk("rst_preempt", int'(preempt), 0);
    chk("rst_Q", int'(q), 0);
    @(negedge clk); #3;
    reset_n = 1'b1;

    for (int k = 0; k < 3; k++) drive(4'b0100, 16'h0500);
    drive(4'b0000, 16'h0000);
    drive(4'b0000, 16'h0000);

    for (int t = 0; t < 5; t++) begin
      drive(4'hF, 16'(($urandom)));
      drive(4'hF, 16'(($urandom)));
      drive(4'hF, 16'(($urandom)));
      c = m_cur;
      drive(4'hF & ~N'(1 << c), 16'(($urandom)));
    end

    for (int k = 0; k < 40; k++) drive(4'b0011, 16'(($urandom)));
    drive(4'b0000, 16'h0000);
    drive(4'b0000, 16'h0000);

    r = '0;
    for (int k = 0; k < 600; k++) begin
      for (int b = 0; b < N; b++)
        if ($urandom_range(7) == 0) r[b] = ~r[b];
      d = 16'($urandom);
      drive(r, d);
    end

    // Asynchronous reset mid-tenure.
    while (!m_busy || m_held < 2) drive(4'b0010, 16'h00A0);
    @(negedge clk); #3;
    reset_n = 1'b0;
    #1;
    chk("async_rst_gnt", int'(gnt), 0);
    chk("async_rst_owner", int'(owner), 0);
    chk("async_rst_preempt", int'(preempt), 0);
    chk("async_rst_Q", int'(q), 0);
    model_reset();
    req = '0;
    @(negedge clk); #3;
    reset_n = 1'b1;

    r = '0;
    for (int k = 0; k < 150; k++) begin
      for (int b = 0; b < N; b++)
        if ($urandom_range(5) == 0) r[b] = ~r[b];
      d = 16'($urandom);
      drive(r, d);
    end

    @(negedge clk);
    @(negedge clk);
    #1;
    chk("scoreboard_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
